// File: rtl/spi_flash_reader_pkg.sv
// Shared constants, state encoding and byte-order helper for the SPI flash reader.
package flash_pkg;

    localparam logic [7:0] FLASH_CMD_READ  = 8'h03;
    localparam int         FLASH_XFER_BITS = 64;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } flash_state_e;

    // The flash streams b0..b3 MSB first, so after 32 left shifts b0 sits in
    // [31:24]; the core wants b0 in [7:0].
    function automatic logic [31:0] flash_le_word(input logic [31:0] s);
        return {s[7:0], s[15:8], s[23:16], s[31:24]};
    endfunction

endpackage

// File: rtl/spi_flash_reader_if.sv
// Core-side read bus of the flash region: strobe/address in, data/busy out.
interface spi_flash_reader_if;
    logic        rstrb;
    logic [23:0] addr;
    logic [31:0] rdata;
    logic        rbusy;

    modport master (output rstrb, output addr, input rdata, input rbusy);
    modport slave  (input rstrb, input addr, output rdata, output rbusy);
endinterface

// File: rtl/spi_flash_reader_spi_clk_div.sv
// Half-period tick generator: tick_o pulses every CLK_DIV cycles, held in
// phase by a synchronous clear.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic tick_o
);
    logic [7:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == 8'(CLK_DIV - 1));

    // Count up, restart on tick or clear.
    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (clr_i || tick_o) cnt_d = '0;
    end

    // Divider counter register.
    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/spi_flash_reader.sv
// Read-only SPI NOR flash port: one READ (0x03) per strobe, returns a
// little-endian 32-bit word, rbusy high for the whole transfer.
module spi_flash_reader
    import flash_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic               clk,
    input  logic               reset,
    spi_flash_reader_if.slave  bus,
    output logic               spi_cs_n,
    output logic               spi_clk,
    output logic               spi_mosi,
    input  logic               spi_miso
);
    flash_state_e state_q, state_d;
    logic [31:0]  out_q, out_d;
    logic [31:0]  in_q, in_d;
    logic [31:0]  rdata_q, rdata_d;
    logic [5:0]   cnt_q, cnt_d;
    logic         cs_n_q, cs_n_d;
    logic         sclk_q, sclk_d;
    logic         mosi_q, mosi_d;
    logic         busy_q, busy_d;
    logic         tick;

    // Word alignment drops the two low address bits.
    logic unused_addr;
    assign unused_addr = &{1'b0, bus.addr[1:0]};

    // The divider only runs during a transfer so each slot starts in phase.
    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (state_q == IDLE),
        .tick_o (tick)
    );

    assign spi_cs_n  = cs_n_q;
    assign spi_clk   = sclk_q;
    assign spi_mosi  = mosi_q;
    assign bus.rdata = rdata_q;
    assign bus.rbusy = busy_q;

    // Next-state: strobe accept in IDLE, bit slots sequenced by divider ticks.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        in_d    = in_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (bus.rstrb) begin
                    out_d   = {FLASH_CMD_READ, bus.addr[23:2], 2'b00};
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = FLASH_CMD_READ[7];
                    cnt_d   = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (tick) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Falling edge: sample, shift, advance the slot.
                        sclk_d = 1'b0;
                        out_d  = {out_q[30:0], 1'b0};
                        // After 32 shifts out_d is all zero, so data slots drive 0.
                        mosi_d = out_d[31];
                        cnt_d  = cnt_q + 6'd1;
                        if (cnt_q[5]) in_d = {in_q[30:0], spi_miso};
                        if (cnt_q == 6'(FLASH_XFER_BITS - 1)) begin
                            rdata_d = flash_le_word(in_d);
                            cs_n_d  = 1'b1;
                            busy_d  = 1'b0;
                            mosi_d  = 1'b0;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end
                    end
                end
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            out_q   <= '0;
            in_q    <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            in_q    <= in_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
        end
    end
endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench: two readers (CLK_DIV=1 and 3) each attached to a behavioural flash.
module tb_spi_flash_reader;
    logic clk;
    logic [1:0]        rst_v;
    logic [1:0]        rstrb_v;
    logic [1:0][23:0]  addr_v;
    logic [1:0][31:0]  rdata_w;
    logic [1:0]        rbusy_w, cs_w, sclk_w, mosi_w;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flash content: known bytes at 0x100, a hash of the address elsewhere.
    function automatic logic [7:0] mem_rd(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h13;
            24'h000101: return 8'h05;
            24'h000102: return 8'h00;
            24'h000103: return 8'h80;
            default:    return 8'(a[7:0] * 8'd37) ^ a[15:8] ^ a[23:16] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic mem_bit(input logic [23:0] a, input int j);
        logic [7:0] b;
        b = mem_rd(a + 24'(j / 8));
        return b[7 - (j % 8)];
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        logic [23:0] b;
        b = {a[23:2], 2'b00};
        return {mem_rd(b + 24'd3), mem_rd(b + 24'd2), mem_rd(b + 24'd1), mem_rd(b)};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int D = (g == 0) ? 1 : 3;
        spi_flash_reader_if bus();
        logic        miso  = 1'b0;
        logic        psclk = 1'b0;
        int          bitn  = 0;
        logic [31:0] cmd   = '0;

        assign bus.rstrb  = rstrb_v[g];
        assign bus.addr   = addr_v[g];
        assign rdata_w[g] = bus.rdata;
        assign rbusy_w[g] = bus.rbusy;

        spi_flash_reader #(.CLK_DIV(D)) dut (
            .clk      (clk),
            .reset    (rst_v[g]),
            .bus      (bus),
            .spi_cs_n (cs_w[g]),
            .spi_clk  (sclk_w[g]),
            .spi_mosi (mosi_w[g]),
            .spi_miso (miso)
        );

        // Mode-0 flash: capture command on rising SCK, present next data bit after falling SCK.
        always @(negedge clk) begin
            if (cs_w[g]) begin
                bitn <= 0;
                cmd  <= '0;
            end else if (sclk_w[g] && !psclk) begin
                if (bitn < 32) cmd <= {cmd[30:0], mosi_w[g]};
                bitn <= bitn + 1;
            end else if (!sclk_w[g] && psclk && bitn >= 32 && bitn < 64) begin
                miso <= mem_bit(cmd[23:0], bitn - 32);
            end
            psclk <= sclk_w[g];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Results of the last do_read.
    int          r_busy, r_rises, r_hmin, r_hmax, r_lmin, r_lmax, r_mviol;
    logic [31:0] r_cmd;
    logic        r_e0ok, r_to;

    task automatic do_read(input int i, input logic [23:0] a, input bit pulse);
        int n, run;
        logic ps, pm, s, m;
        @(posedge clk); #1;
        addr_v[i]  = a;
        rstrb_v[i] = 1'b1;
        @(posedge clk); #1;
        rstrb_v[i] = 1'b0;
        r_e0ok  = (rbusy_w[i] === 1'b1) && (cs_w[i] === 1'b0);
        r_cmd   = '0; r_rises = 0; r_mviol = 0; r_to = 1'b0;
        r_hmin  = 9999; r_hmax = 0; r_lmin = 9999; r_lmax = 0;
        n = 0; run = 1; ps = sclk_w[i]; pm = mosi_w[i];
        while (rbusy_w[i] && !r_to) begin
            @(posedge clk); #1;
            n++;
            rstrb_v[i] = pulse && (n == 10 || n == 50);
            if (pulse) addr_v[i] = 24'h000200;
            s = sclk_w[i];
            m = mosi_w[i];
            if (m !== pm && !(ps && !s)) r_mviol++;
            if (s === ps) run++;
            else begin
                if (ps) begin
                    if (run < r_hmin) r_hmin = run;
                    if (run > r_hmax) r_hmax = run;
                end else begin
                    if (run < r_lmin) r_lmin = run;
                    if (run > r_lmax) r_lmax = run;
                end
                run = 1;
                if (s) begin
                    r_rises++;
                    if (r_rises <= 32) r_cmd = {r_cmd[30:0], m};
                    else if (m) r_mviol++;
                end
            end
            ps = s; pm = m;
            if (n > 128 * 3 + 16) r_to = 1'b1;
        end
        rstrb_v[i] = 1'b0;
        r_busy = n;
    endtask

    typedef struct {
        int          inst;
        logic [23:0] addr;
        logic [31:0] exp_rdata;
        logic [31:0] exp_cmd;
        int          exp_busy;
    } vec_t;

    vec_t vecs[6];

    task automatic check_read(input string nm, input int i, input logic [31:0] er,
                              input logic [31:0] ec, input int eb);
        int d;
        d = (i == 0) ? 1 : 3;
        chk({nm, " timeout"}, 32'(r_to), 0);
        chk({nm, " busy/cs at E0"}, 32'(r_e0ok), 1);
        chk({nm, " rdata"}, rdata_w[i], er);
        chk({nm, " mosi cmd"}, r_cmd, ec);
        chk({nm, " busy cycles"}, 32'(r_busy), 32'(eb));
        chk({nm, " sck rises"}, 32'(r_rises), 64);
        chk({nm, " high half min"}, 32'(r_hmin), 32'(d));
        chk({nm, " high half max"}, 32'(r_hmax), 32'(d));
        chk({nm, " low half min"}, 32'(r_lmin), 32'(d));
        chk({nm, " low half max"}, 32'(r_lmax), 32'(d));
        chk({nm, " mosi timing"}, 32'(r_mviol), 0);
        chk({nm, " cs_n after"}, 32'(cs_w[i]), 1);
    endtask

    initial begin
        int lows[$], gaps[$];
        int run, k;
        logic pc, c;
        logic [23:0] ra;
        int ri;

        vecs[0] = '{0, 24'h000100, 32'h80000513, 32'h03000100, 128};
        vecs[1] = '{0, 24'h000103, 32'h80000513, 32'h03000100, 128};
        vecs[2] = '{1, 24'hFFFFFC, exp_word(24'hFFFFFC), 32'h03FFFFFC, 384};
        vecs[3] = '{0, 24'h000000, exp_word(24'h000000), 32'h03000000, 128};
        vecs[4] = '{1, 24'h000101, 32'h80000513, 32'h03000100, 384};
        vecs[5] = '{0, 24'hABCDEF, exp_word(24'hABCDEF), 32'h03ABCDEC, 128};

        rst_v = 2'b00; rstrb_v = 2'b00; addr_v = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset%0d cs_n", i), 32'(cs_w[i]), 1);
            chk($sformatf("reset%0d sclk", i), 32'(sclk_w[i]), 0);
            chk($sformatf("reset%0d mosi", i), 32'(mosi_w[i]), 0);
            chk($sformatf("reset%0d rbusy", i), 32'(rbusy_w[i]), 0);
            chk($sformatf("reset%0d rdata", i), rdata_w[i], 0);
        end
        rst_v = 2'b11;

        for (int v = 0; v < 6; v++) begin
            do_read(vecs[v].inst, vecs[v].addr, 1'b0);
            check_read($sformatf("vec%0d", v), vecs[v].inst, vecs[v].exp_rdata,
                       vecs[v].exp_cmd, vecs[v].exp_busy);
        end

        // Strobes during a transfer are ignored.
        do_read(0, 24'h000100, 1'b1);
        check_read("ignore", 0, 32'h80000513, 32'h03000100, 128);
        k = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (!cs_w[0]) k++;
        end
        chk("ignore no second cmd", 32'(k), 0);

        // Reset mid-transfer aborts and clears rdata.
        @(posedge clk); #1;
        addr_v[0] = 24'h000400; rstrb_v[0] = 1'b1;
        @(posedge clk); #1;
        rstrb_v[0] = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        chk("abort busy before", 32'(rbusy_w[0]), 1);
        rst_v[0] = 1'b0;
        @(posedge clk); #1;
        chk("abort cs_n", 32'(cs_w[0]), 1);
        chk("abort rbusy", 32'(rbusy_w[0]), 0);
        chk("abort rdata", rdata_w[0], 0);
        chk("abort sclk", 32'(sclk_w[0]), 0);
        rst_v[0] = 1'b1;
        do_read(0, 24'h000400, 1'b0);
        check_read("after abort", 0, exp_word(24'h000400), 32'h03000400, 128);

        // Back-to-back with rstrb held high.
        @(posedge clk); #1;
        addr_v[0] = 24'h000100; rstrb_v[0] = 1'b1;
        pc = 1'b0; run = 0;
        for (int n = 0; n < 1000 && lows.size() < 3; n++) begin
            @(posedge clk); #1;
            c = cs_w[0];
            if (c == pc) run++;
            else begin
                if (!pc) lows.push_back(run);
                else     gaps.push_back(run);
                pc = c; run = 1;
            end
        end
        rstrb_v[0] = 1'b0;
        chk("b2b transactions", 32'(lows.size()), 3);
        chk("b2b gaps", 32'(gaps.size()), 2);
        foreach (lows[j]) chk($sformatf("b2b cs low %0d", j), 32'(lows[j]), 128);
        foreach (gaps[j]) chk($sformatf("b2b cs gap %0d", j), 32'(gaps[j]), 1);
        repeat (4) @(posedge clk);
        #1;
        chk("b2b idle rbusy", 32'(rbusy_w[0]), 0);
        chk("b2b rdata", rdata_w[0], 32'h80000513);

        // Random reads on both instances.
        for (int r = 0; r < 6; r++) begin
            ri = int'($urandom_range(0, 1));
            ra = 24'($urandom);
            do_read(ri, ra, 1'b0);
            check_read($sformatf("rnd%0d", r), ri, exp_word(ra), {8'h03, ra[23:2], 2'b00},
                       (ri == 0) ? 128 : 384);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
